// File: rtl/dmem_scheduler.sv
// Data-memory port scheduler: an in-order committed-store queue shares the write port,
// while loads go to memory one at a time or are forwarded from the queue.
module dmem_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int STQ_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_req_valid,
  output logic                          ld_req_ready,
  input  logic [ADDR_WIDTH-1:0]         ld_req_addr,
  input  logic [TAG_WIDTH-1:0]          ld_req_tag,
  output logic                          ld_resp_valid,
  output logic [DATA_WIDTH-1:0]         ld_resp_data,
  output logic [TAG_WIDTH-1:0]          ld_resp_tag,
  input  logic                          st_req_valid,
  output logic                          st_req_ready,
  input  logic [ADDR_WIDTH-1:0]         st_req_addr,
  input  logic [DATA_WIDTH-1:0]         st_req_data,
  input  logic                          flush,
  output logic                          mem_write_en,
  output logic [ADDR_WIDTH-1:0]         waddr,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          mem_rd_en,
  output logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          rdata_valid,
  output logic                          stq_empty,
  output logic [$clog2(STQ_DEPTH):0]   stq_count
);

  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] stq_addr_q [STQ_DEPTH];
  logic [DATA_WIDTH-1:0] stq_data_q [STQ_DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ld_busy_q, drop_q;
  logic [TAG_WIDTH-1:0]  ld_tag_q;
  logic                  fwd_valid_q;
  logic [DATA_WIDTH-1:0] fwd_data_q;
  logic [TAG_WIDTH-1:0]  fwd_tag_q;

  logic                  full, ld_accept, enq, drain, rd_ret, mem_resp, fwd_resp;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic [PTR_W-1:0]      best_age;
  logic [STQ_DEPTH-1:0]  ent_match;
  logic [PTR_W-1:0]      ent_age [STQ_DEPTH];

  // Age 0 is the head (oldest); an entry is live when its age is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < STQ_DEPTH; gi++) begin : g_ent
      assign ent_age[gi]   = PTR_W'(gi) - head_q;
      assign ent_match[gi] = ({1'b0, ent_age[gi]} < count_q) &&
                             (stq_addr_q[gi][ADDR_WIDTH-1:2] == ld_req_addr[ADDR_WIDTH-1:2]);
    end
  endgenerate

  // Youngest matching store wins so the load sees the latest committed value.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    best_age = '0;
    for (int i = 0; i < STQ_DEPTH; i++) begin
      if (ent_match[i] && (!hit || ent_age[i] >= best_age)) begin
        hit      = 1'b1;
        best_age = ent_age[i];
        hit_data = stq_data_q[i];
      end
    end
  end

  assign full         = (count_q == CNT_W'(STQ_DEPTH));
  assign ld_req_ready = rst & ~ld_busy_q & ~full & ~flush;
  assign st_req_ready = rst & ~full;
  assign ld_accept    = ld_req_valid & ld_req_ready;
  assign enq          = st_req_valid & st_req_ready;
  assign drain        = rst & ~ld_accept & (count_q != '0);
  assign count_d      = count_q + CNT_W'(enq) - CNT_W'(drain);

  assign mem_rd_en    = ld_accept & ~hit;
  assign raddr        = mem_rd_en ? ld_req_addr : '0;
  assign mem_write_en = drain;
  assign waddr        = drain ? stq_addr_q[head_q] : '0;
  assign wdata        = drain ? stq_data_q[head_q] : '0;

  // A flush in the response cycle suppresses either kind of response.
  assign rd_ret        = rdata_valid & ld_busy_q;
  assign mem_resp      = rd_ret & ~drop_q & ~flush;
  assign fwd_resp      = fwd_valid_q & ~flush;
  assign ld_resp_valid = mem_resp | fwd_resp;
  assign ld_resp_data  = mem_resp ? rdata : (fwd_resp ? fwd_data_q : '0);
  assign ld_resp_tag   = mem_resp ? ld_tag_q : (fwd_resp ? fwd_tag_q : '0);

  assign stq_empty = (count_q == '0);
  assign stq_count = count_q;

  always_ff @(posedge clk) begin
    if (enq) begin
      stq_addr_q[tail_q] <= st_req_addr;
      stq_data_q[tail_q] <= st_req_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ld_busy_q   <= 1'b0;
      drop_q      <= 1'b0;
      ld_tag_q    <= '0;
      fwd_valid_q <= 1'b0;
      fwd_data_q  <= '0;
      fwd_tag_q   <= '0;
    end else begin
      if (enq)   tail_q <= tail_q + PTR_W'(1);
      if (drain) head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      if (mem_rd_en) begin
        ld_busy_q <= 1'b1;
        ld_tag_q  <= ld_req_tag;
      end else if (rd_ret) begin
        ld_busy_q <= 1'b0;
      end
      if (rd_ret)                drop_q <= 1'b0;
      else if (flush & ld_busy_q) drop_q <= 1'b1;
      fwd_valid_q <= ld_accept & hit;
      if (ld_accept & hit) begin
        fwd_data_q <= hit_data;
        fwd_tag_q  <= ld_req_tag;
      end
    end
  end

endmodule

// File: doc/dmem_scheduler.md
Name: dmem_scheduler

Overview:
Sequences the single read port and single write port of the data memory between the load pipeline and the committed-store path. Buffers committed stores in an in-order store queue, drains them when the port is free, and issues loads one at a time. Loads that hit a queued store are served by store-to-load forwarding without a memory access. Sits between the LSU/commit logic and the data-memory interface of the memory block.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data word width
TAG_WIDTH, 6, load tag (ROB/LQ index) width
STQ_DEPTH, 4, store queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
ld_req_valid  in  1  load request valid
ld_req_ready  out  1  load request accepted when valid&ready
ld_req_addr  in  ADDR_WIDTH  load word address
ld_req_tag  in  TAG_WIDTH  load tag
ld_resp_valid  out  1  load result valid (one-cycle pulse)
ld_resp_data  out  DATA_WIDTH  load result
ld_resp_tag  out  TAG_WIDTH  tag of result
st_req_valid  in  1  committed store valid
st_req_ready  out  1  store accepted when valid&ready
st_req_addr  in  ADDR_WIDTH  store word address
st_req_data  in  DATA_WIDTH  store data
flush  in  1  pipeline flush; cancels load activity only
mem_write_en  out  1  memory write strobe
waddr  out  ADDR_WIDTH  memory write address
wdata  out  DATA_WIDTH  memory write data
mem_rd_en  out  1  memory read strobe
raddr  out  ADDR_WIDTH  memory read address
rdata  in  DATA_WIDTH  memory read data
rdata_valid  in  1  memory read data valid (>=1 cycle after mem_rd_en)
stq_empty  out  1  store queue empty (fence support)
stq_count  out  $clog2(STQ_DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async): queue empty, head/tail pointers 0, ld_busy=0, drop=0, forward register cleared. Outputs: ld_req_ready=0, st_req_ready=0, ld_resp_valid=0, mem_write_en=0, mem_rd_en=0, stq_empty=1, stq_count=0. Data/address outputs 0.
- Store queue: circular FIFO; st_req_ready = !full. Enqueue on st_req_valid&st_req_ready. Whole-word, word-aligned; address comparison uses addr[ADDR_WIDTH-1:2].
- One port action per cycle, chosen combinationally from registered state and current inputs; mem_* outputs valid in that same cycle only:
  1. LOAD: ld_req_valid & ld_req_ready. ld_req_ready = !ld_busy & !full & !flush. On acceptance, the address is compared against all valid queue entries as registered at cycle start. A store enqueued in the same cycle is not visible.
     - Hit: the youngest matching entry's data is registered. ld_resp_valid=1 the next cycle with that data and the tag. No mem_rd_en.
     - Miss: mem_rd_en=1, raddr=ld_req_addr. Set ld_busy and save the tag.
  2. DRAIN: no load accepted and queue non-empty. mem_write_en=1, waddr/wdata = head entry. Pop head.
  3. A full queue forces DRAIN, because loads are blocked by !full.
- Read return: when rdata_valid & ld_busy, clear ld_busy. If drop=0, ld_resp_valid=1 combinationally in the same cycle, with ld_resp_data=rdata and ld_resp_tag=saved tag. rdata_valid with ld_busy=0 is ignored.
- Forward and memory responses never coincide. Forward requires ld_busy=0, and memory latency is >=1 cycle.
- Flush:
  - If ld_busy, set drop. The pending response is swallowed and drop clears together with ld_busy.
  - Cancels a forward response due next cycle.
  - The queue and store drain are unaffected; committed stores always reach memory.
  - Load acceptance is blocked in the flush cycle.
- Simultaneous enqueue and drain when full: not possible (st_req_ready=0). Enqueue and drain in the same cycle otherwise: count unchanged.
- stq_empty and stq_count are registered state, not the next-cycle value.
- Stores drain in strict FIFO order. Loads never bypass a matching store; forwarding guarantees this.

Test Plan:
- Reset mid-drain: queue holds 3 stores, assert rst=0 -> next edge-independent: mem_write_en=0, stq_empty=1, stq_count=0. After release, no stale writes occur.
- Store drain: enqueue (0x1000,0xAA), (0x1004,0xBB) with no loads -> writes in consecutive cycles in that order. stq_empty=1 afterwards.
- Forwarding: queue (0x1008,0x11) then (0x1008,0x22), load 0x1008 tag 5 -> no mem_rd_en. The next cycle gives ld_resp_valid, data 0x22, tag 5.
- Memory load with priority: queue holds 1 store, load 0x1010 tag 3 arrives -> mem_rd_en same cycle, store drains next cycle. rdata_valid 0xDEAD later gives resp data 0xDEAD, tag 3. A second load is not ready until then.
- Full queue: 4 stores queued with ld_req_valid held -> st_req_ready=0, ld_req_ready=0, mem_write_en=1. The load is accepted after space frees.
- Flush with outstanding read: load tag 7 misses, flush next cycle, then rdata_valid -> no ld_resp_valid. The queued store still writes, and ld_req_ready returns to 1.
